// File: rtl/accu_pkg.sv
// Shared definitions for the accumulator datapath: op encodings and signed range helpers.
package accu_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // Callers truncate the 64-bit result to their own width.
  function automatic logic [63:0] max_pos(input int unsigned width);
    return (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] max_neg(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/accu_addsub_sat.sv
// Combinational signed add/subtract with overflow detection and optional saturation.
module accu_addsub_sat
  import accu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             sat_en,
  output logic [WIDTH-1:0] result,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MaxPos = WIDTH'(max_pos(WIDTH));
  localparam logic [WIDTH-1:0] MaxNeg = WIDTH'(max_neg(WIDTH));

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;

  always_comb begin
    b_eff  = sub ? ~b : b;
    raw    = a + b_eff + WIDTH'(sub);
    // Comparing against the inverted operand covers both add and subtract rules.
    ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
    result = raw;
    if (sat_en && ovf) begin
      result = a[WIDTH-1] ? MaxNeg : MaxPos;
    end
  end

endmodule

// File: rtl/accu_seq.sv
// Clocked signed accumulator: one add/sub/load/clear per accepted beat, registered result
// and flags behind a valid/ready handshake.
module accu_seq
  import accu_pkg::*;
#(
  parameter int unsigned WIDTH       = 8,
  parameter bit          SAT_DEFAULT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_op,
  input  logic             sat_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_zero,
  output logic             out_neg,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_ovf_q, out_ovf_d;
  logic             sticky_q, sticky_d;
  logic             sat_q, sat_d;

  logic             accept;
  logic             sat_mode;
  logic [WIDTH-1:0] as_result;
  logic             as_ovf;
  logic [WIDTH-1:0] op_result;
  logic             op_ovf;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  // The beat's own sat_en governs its op; the register only retains the last accepted mode.
  assign sat_mode = accept ? sat_en : sat_q;

  accu_addsub_sat #(
    .WIDTH(WIDTH)
  ) u_addsub (
    .a     (acc_q),
    .b     (in_data),
    .sub   (in_op == OP_SUB),
    .sat_en(sat_mode),
    .result(as_result),
    .ovf   (as_ovf)
  );

  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    unique case (in_op)
      OP_ADD, OP_SUB: begin
        op_result = as_result;
        op_ovf    = as_ovf;
      end
      OP_LOAD: op_result = in_data;
      OP_CLR:  op_result = '0;
      default: op_result = '0;
    endcase
  end

  always_comb begin
    acc_d       = acc_q;
    out_data_d  = out_data_q;
    out_ovf_d   = out_ovf_q;
    sticky_d    = sticky_q;
    sat_d       = sat_q;
    out_valid_d = out_valid_q && !out_ready;
    if (accept) begin
      acc_d       = op_result;
      out_data_d  = op_result;
      out_ovf_d   = op_ovf;
      sticky_d    = (in_op == OP_CLR) ? 1'b0 : (sticky_q || op_ovf);
      sat_d       = sat_en;
      out_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_ovf_q   <= 1'b0;
      sticky_q    <= 1'b0;
      sat_q       <= SAT_DEFAULT;
    end else begin
      acc_q       <= acc_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_ovf_q   <= out_ovf_d;
      sticky_q    <= sticky_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_ovf    = out_ovf_q;
  assign out_zero   = (out_data_q == '0);
  assign out_neg    = out_data_q[WIDTH-1];
  assign ovf_sticky = sticky_q;

endmodule
